// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - load handshake, serial drive and response bundle for serial_pattern_tx
interface serial_pattern_tx_if #(
    parameter int WIDTH = 28
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             resp_in;
    logic [WIDTH-1:0] resp_data;
    logic             busy;
    logic             done;

    // Stimulus side: offers words, returns the detector response
    modport master (
        output load_valid,
        output load_data,
        output resp_in,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  resp_data,
        input  busy,
        input  done
    );

    // Engine side
    modport slave (
        input  load_valid,
        input  load_data,
        input  resp_in,
        output load_ready,
        output ser_out,
        output ser_valid,
        output resp_data,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - parallel-to-serial stimulus engine with response capture (option: SERIAL_PATTERN_TX_CHECK_EN)
module serial_pattern_tx #(
    parameter int WIDTH    = 28,
    parameter int RESP_LAT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_pattern_tx_if.slave      bus
`ifdef SERIAL_PATTERN_TX_CHECK_EN
    ,
    input  logic [WIDTH-1:0]        exp_data,
    output logic                    mismatch
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int DRAIN_LAST = (RESP_LAT > 0) ? RESP_LAT - 1 : 0;
    localparam logic [CW-1:0] LAST_BIT_C   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DRAIN_LAST_C = CW'(DRAIN_LAST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] resp_q, resp_d;
    logic             accept;
    logic             last_bit;
    logic             tap;

    assign accept   = (state_q == S_IDLE) && bus.load_valid;
    assign last_bit = (cnt_q == LAST_BIT_C);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: SHIFT runs WIDTH clocks, DRAIN covers the response latency
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    state_d = (RESP_LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST_C) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath decode: next values of the registered outputs, shifter and counter.
    // The first bit is driven straight from load_data so it appears in the cycle after accept;
    // the shift register therefore holds the remaining bits, already left-aligned.
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d     = {bus.load_data[WIDTH-2:0], 1'b0};
                    cnt_d       = '0;
                    ser_out_d   = bus.load_data[WIDTH-1];
                    ser_valid_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                end else begin
                    ser_out_d   = shreg_q[WIDTH-1];
                    ser_valid_d = 1'b1;
                    shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d       = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        busy_d = (state_d == S_SHIFT) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Response tap: ser_valid delayed to line up with the detector's answer for each bit
    generate
        if (RESP_LAT == 0) begin : g_nolat
            assign tap = ser_valid_q;
        end else begin : g_lat
            logic [RESP_LAT-1:0] dly_q;

            // RESP_LAT-stage delay line of ser_valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= (dly_q << 1) | RESP_LAT'(ser_valid_q);
                end
            end

            assign tap = dly_q[RESP_LAT-1];
        end
    endgenerate

    // Response collection: cleared on accept, one sample per tapped clock, held after DONE
    always_comb begin
        resp_d = resp_q;
        if (accept) begin
            resp_d = '0;
        end else if (tap) begin
            resp_d = {resp_q[WIDTH-2:0], bus.resp_in};
        end
    end

    // Response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

`ifdef SERIAL_PATTERN_TX_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             mismatch_q;

    // Expected word captured at accept; verdict formed during DONE once resp_data is final
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else if (accept) begin
            exp_q      <= exp_data;
            mismatch_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            mismatch_q <= (resp_q != exp_q);
        end
    end

    assign mismatch = mismatch_q;
`endif

    assign bus.load_ready = (state_q == S_IDLE);
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.resp_data  = resp_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - self-checking bench for serial_pattern_tx (RESP_LAT 0 and 2 instances)
module tb_serial_pattern_tx;

    localparam int W = 28;
    localparam logic [W-1:0] LB  = 28'b0100110010100101011011011011;
    localparam logic [W-1:0] DET = 28'b1000011100000110001100010001;
    localparam logic [W-1:0] A5  = 28'hA5A5A5A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]   lv = '0;
    logic [W-1:0] ld [2];
    logic [W-1:0] ex [2];
    logic [1:0]   pm = '0;
    logic [W-1:0] patv = '0;
    logic         resp0;
    logic         d1, d2;

    logic [1:0]   o_ser, o_sv, o_busy, o_done, o_rdy, o_mm;
    logic [W-1:0] o_resp [2];

    serial_pattern_tx_if #(.WIDTH(W)) if0 ();
    serial_pattern_tx_if #(.WIDTH(W)) if2 ();

    serial_pattern_tx #(.WIDTH(W), .RESP_LAT(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (if0)
`ifdef SERIAL_PATTERN_TX_CHECK_EN
        ,
        .exp_data (ex[0]),
        .mismatch (o_mm[0])
`endif
    );

    serial_pattern_tx #(.WIDTH(W), .RESP_LAT(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (if2)
`ifdef SERIAL_PATTERN_TX_CHECK_EN
        ,
        .exp_data (ex[1]),
        .mismatch (o_mm[1])
`endif
    );

`ifndef SERIAL_PATTERN_TX_CHECK_EN
    assign o_mm = '0;
`endif

    assign if0.load_valid = lv[0];
    assign if0.load_data  = ld[0];
    assign if0.resp_in    = resp0;
    assign if2.load_valid = lv[1];
    assign if2.load_data  = ld[1];
    assign if2.resp_in    = d2;

    assign o_ser  = {if2.ser_out,    if0.ser_out};
    assign o_sv   = {if2.ser_valid,  if0.ser_valid};
    assign o_busy = {if2.busy,       if0.busy};
    assign o_done = {if2.done,       if0.done};
    assign o_rdy  = {if2.load_ready, if0.load_ready};
    assign o_resp[0] = if0.resp_data;
    assign o_resp[1] = if2.resp_data;

    // ---------------- behavioural model ----------------
    // mt = cycle number relative to the accept edge (0 = never loaded / reset)
    int           mt [2] = '{0, 0};
    logic [W-1:0] mw [2];
    logic [W-1:0] er [2];
    logic [W-1:0] me [2];
    logic         mm [2] = '{1'b0, 1'b0};

    function automatic int lat(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic bit m_idle(input int i);
        return (mt[i] == 0) || (mt[i] >= W + lat(i) + 2);
    endfunction

    // Stimulus-side detector stand-in for instance 0: either loopback or a fixed gnt pattern
    always_comb begin
        resp0 = o_ser[0];
        if (pm[0]) begin
            resp0 = 1'b0;
            if (mt[0] >= 1 && mt[0] <= W) resp0 = patv[5'(W - mt[0])];
        end
    end

    // Two-flop loopback delay for the RESP_LAT=2 instance
    always @(posedge clk) begin
        d1 <= o_ser[1];
        d2 <= d1;
    end

    // Model timeline update
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mt[i] <= 0;
                mm[i] <= 1'b0;
            end else if (m_idle(i) && lv[i]) begin
                mt[i] <= 1;
                mw[i] <= ld[i];
                er[i] <= (i == 0 && pm[0]) ? patv : ld[i];
                me[i] <= ex[i];
                mm[i] <= 1'b0;
            end else if (mt[i] != 0 && mt[i] < W + lat(i) + 2) begin
                mt[i] <= mt[i] + 1;
                if (mt[i] + 1 == W + lat(i) + 2) mm[i] <= (er[i] != me[i]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int t;
            int l;
            logic e_sv, e_so;
            t = mt[i];
            l = lat(i);
            e_sv = (t >= 1 && t <= W);
            e_so = e_sv ? mw[i][5'(W - t)] : 1'b0;
            chk($sformatf("ser_valid[%0d] t=%0d", i, t), 32'(o_sv[i]), 32'(e_sv));
            chk($sformatf("ser_out[%0d] t=%0d", i, t), 32'(o_ser[i]), 32'(e_so));
            chk($sformatf("busy[%0d] t=%0d", i, t), 32'(o_busy[i]), 32'(t >= 1 && t <= W + l));
            chk($sformatf("done[%0d] t=%0d", i, t), 32'(o_done[i]), 32'(t == W + l + 1));
            chk($sformatf("load_ready[%0d] t=%0d", i, t), 32'(o_rdy[i]), 32'(t == 0 || t >= W + l + 2));
            if (t == 0) chk($sformatf("resp_data_rst[%0d]", i), 32'(o_resp[i]), 32'h0);
            else if (t >= W + l + 1) chk($sformatf("resp_data[%0d] t=%0d", i, t), 32'(o_resp[i]), 32'(er[i]));
`ifdef SERIAL_PATTERN_TX_CHECK_EN
            if (t != W + l + 1) chk($sformatf("mismatch[%0d] t=%0d", i, t), 32'(o_mm[i]), 32'(mm[i]));
`endif
        end
    end

    // One transfer on instance i; returns done cycle, busy cycle count and observed serial bits
    task automatic xfer(input int i, input logic [W-1:0] w, input bit p, input logic [W-1:0] e,
                        output int done_at, output int busy_n, output logic [W-1:0] obs);
        done_at = -1;
        busy_n  = 0;
        obs     = '0;
        @(posedge clk); #1;
        lv[i] = 1'b1; ld[i] = w; ex[i] = e;
        if (i == 0) pm[0] = p;
        @(posedge clk); #1;
        lv[i] = 1'b0; ld[i] = W'($urandom);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (o_busy[i]) busy_n++;
            if (c <= W) obs[W - c] = o_ser[i];
            if (o_done[i]) begin
                done_at = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_at < 0) chk("xfer_timeout", 32'(done_at), 32'd0);
        @(posedge clk); #1;
    endtask

    int dc, bc, nd, k, cyc;
    int dt [3];
    logic [W-1:0] ob;
    logic [W-1:0] hw [4];

    initial begin
        ld[0] = '0; ld[1] = '0; ex[0] = '0; ex[1] = '0;
        hw[0] = 28'h1234567; hw[1] = 28'hFEDCBA9; hw[2] = 28'h0F0F0F0; hw[3] = 28'h5555555;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_ready", 32'(o_rdy[0]), 32'd1);
        chk("rst_resp_data", 32'(o_resp[0]), 32'd0);
        chk("rst_ser_out", 32'(o_ser[0]), 32'd0);
        rst_n = 1'b1;

        // Loopback, RESP_LAT=0
        xfer(0, LB, 1'b0, LB, dc, bc, ob);
        chk("lb_done_cycle", 32'(dc), 32'd29);
        chk("lb_busy_cycles", 32'(bc), 32'd28);
        chk("lb_first_bits", 32'(ob[W-1:W-6]), 32'b010011);
        chk("lb_resp", 32'(o_resp[0]), 32'(LB));

        // Detector-response pattern
        patv = DET;
        xfer(0, LB, 1'b1, DET, dc, bc, ob);
        chk("det_resp", 32'(o_resp[0]), 32'b1000011100000110001100010001);
`ifdef SERIAL_PATTERN_TX_CHECK_EN
        chk("det_mismatch_clear", 32'(o_mm[0]), 32'd0);
`endif
        xfer(0, LB, 1'b1, DET ^ 28'd1, dc, bc, ob);
`ifdef SERIAL_PATTERN_TX_CHECK_EN
        chk("det_mismatch_set", 32'(o_mm[0]), 32'd1);
`endif
        pm[0] = 1'b0;

        // Latency instance
        xfer(1, A5, 1'b0, A5, dc, bc, ob);
        chk("lat_done_cycle", 32'(dc), 32'd31);
        chk("lat_busy_cycles", 32'(bc), 32'd30);
        chk("lat_resp", 32'(o_resp[1]), 32'hA5A5A5A);

        // Continuous load_valid: three words back to back
        @(posedge clk); #1;
        lv[0] = 1'b1; ld[0] = hw[0]; ex[0] = '0;
        k = 1; nd = 0; cyc = 0;
        for (int c = 0; c < 200 && nd < 3; c++) begin
            @(negedge clk);
            cyc++;
            if (o_done[0]) begin
                dt[nd] = cyc;
                nd++;
            end
            @(posedge clk); #1;
            if (mt[0] == 1 && k < 4) begin
                ld[0] = hw[k];
                k++;
            end
            if (nd == 3) lv[0] = 1'b0;
        end
        lv[0] = 1'b0;
        chk("hs_words_done", 32'(nd), 32'd3);
        chk("hs_spacing_1", 32'(dt[1] - dt[0]), 32'd30);
        chk("hs_spacing_2", 32'(dt[2] - dt[1]), 32'd30);
        chk("hs_last_resp", 32'(o_resp[0]), 32'(hw[2]));

        // Reset during cycle 10 of a transfer
        @(posedge clk); #1;
        lv[0] = 1'b1; ld[0] = LB;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(o_busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(o_busy[0]), 32'd0);
        chk("mid_rst_ser_valid", 32'(o_sv[0]), 32'd0);
        chk("mid_rst_ready", 32'(o_rdy[0]), 32'd1);
        chk("mid_rst_resp", 32'(o_resp[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        xfer(0, A5, 1'b0, A5, dc, bc, ob);
        chk("post_rst_done_cycle", 32'(dc), 32'd29);
        chk("post_rst_resp", 32'(o_resp[0]), 32'hA5A5A5A);

        // Edge words
        xfer(0, '0, 1'b0, '0, dc, bc, ob);
        chk("zeros_resp", 32'(o_resp[0]), 32'h0);
        xfer(0, '1, 1'b0, '1, dc, bc, ob);
        chk("ones_resp", 32'(o_resp[0]), 32'hFFFFFFF);
        xfer(1, '1, 1'b0, '1, dc, bc, ob);
        chk("lat_ones_resp", 32'(o_resp[1]), 32'hFFFFFFF);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Parallel-to-serial stimulus engine for the serial pattern detector. Accepts a WIDTH-bit word through a valid/ready load handshake and drives it onto the detector's serial input one bit per clock, MSB first. It collects the detector's per-bit response into a WIDTH-bit word, then signals completion. This lets a detector run in a self-checking loop without a bench driving bits by hand.

## Interface
- WIDTH, 28: word length in bits, 2..32
- RESP_LAT, 0: clocks from a bit on ser_out to its response on resp_in, 0..3
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  load_data valid
- load_ready  output  1  block can accept a word
- load_data  input  WIDTH  word to transmit; bit WIDTH-1 is sent first
- ser_out  output  1  serial bit to detector input
- ser_valid  output  1  ser_out carries a payload bit this cycle
- resp_in  input  1  detector response (gnt)
- resp_data  output  WIDTH  collected responses; first response lands in bit WIDTH-1
- busy  output  1  transfer in progress (SHIFT or DRAIN)
- done  output  1  one-cycle pulse, resp_data complete

## Operation
- Reset values: state IDLE, load_ready 1, ser_out 0, ser_valid 0, resp_data 0, busy 0, done 0, bit counter 0, response delay line cleared.
- IDLE:
  - load_ready=1.
  - On load_valid&&load_ready: register load_data into the shift register, clear resp_data, counter=0, go to SHIFT.
- SHIFT:
  - ser_out = shift register bit WIDTH-1; ser_valid=1; shift left by one each clock; counter+1.
  - After the bit at counter==WIDTH-1, go to DRAIN if RESP_LAT>0, else DONE.
- DRAIN: ser_valid=0, ser_out=0. Stay exactly RESP_LAT cycles, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Response capture:
  - ser_valid feeds a RESP_LAT-stage delay line. With RESP_LAT=0 the tap is ser_valid itself.
  - On any clock where the tap is 1, resp_data <= {resp_data[WIDTH-2:0], resp_in}.
  - Exactly WIDTH samples are taken per transfer.
- resp_data holds its value from DONE until the next accepted load.
- load_valid outside IDLE is ignored. load_data needs to be stable only in the accept cycle.
- rst_n low mid-transfer aborts immediately to reset values. No partial done is produced.
- Counter width is clog2(WIDTH)+1. The counter never wraps within a transfer.

## Timing
- The accept edge is cycle 0. Bit k (k=0..WIDTH-1) is on ser_out during cycle k+1.
- resp_in is sampled at the end of cycle k+1+RESP_LAT.
- done is high in cycle WIDTH+RESP_LAT+1. load_ready returns high in cycle WIDTH+RESP_LAT+2.
- Back-to-back throughput: one word per WIDTH+RESP_LAT+2 cycles.
- busy is high in cycles 1..WIDTH+RESP_LAT.
- All outputs are registered except load_ready, which decodes state directly. No combinational path from resp_in to any output.

## Configuration
- SERIAL_PATTERN_TX_CHECK_EN defined: adds two ports.
  - input exp_data[WIDTH-1:0], captured alongside load_data at accept.
  - output mismatch (1 bit, reset 0). It is updated on the DONE cycle to (resp_data != expected) and held until the next accept, which clears it to 0.
- Not defined: neither port exists, and there is no compare logic.

## Test plan
- Loopback: WIDTH=28, RESP_LAT=0, resp_in tied to ser_out, load 28'b0100110010100101011011011011.
  - ser_out emits 0,1,0,0,1,1,… in cycles 1..28.
  - done pulses in cycle 29; resp_data equals the loaded word.
- Detector hookup: resp_in driven by the pattern detector's gnt, same word.
  - resp_data = 28'b1000011100000110001100010001.
  - With CHECK_EN and exp_data equal to that value, mismatch=0. With exp_data bit 0 flipped, mismatch=1.
- Latency: RESP_LAT=2, resp_in = ser_out delayed 2 flops, load 28'hA5A5A5A.
  - resp_data = 28'hA5A5A5A.
  - busy is high in cycles 1..30; done pulses in cycle 31.
- Handshake: hold load_valid=1 continuously with a new word every accept.
  - A word is accepted every 30 cycles (RESP_LAT=0).
  - load_valid asserted while busy leaves the shift register unchanged.
- Reset mid-operation: deassert rst_n at cycle 10 of a transfer.
  - All outputs return to reset values immediately. done never pulses.
  - After release, a new load completes normally.
- Edge word: all-zeros, then all-ones, with loopback. resp_data is 0 and then 28'hFFFFFFF. done pulses once per word.
